// File: rtl/sub_seq_ctl_if.sv
// Start/busy/done handshake and operand/result bundle for sub_seq_ctl.
// The zero flag exists only when SUB_SEQ_ZERO_FLAG_EN is defined.
interface sub_seq_ctl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] f;
    logic             cout;
    logic             overflow;
`ifdef SUB_SEQ_ZERO_FLAG_EN
    logic             zero;

    modport master (
        output start, op, a, b,
        input  busy, done, f, cout, overflow, zero
    );
    modport slave (
        input  start, op, a, b,
        output busy, done, f, cout, overflow, zero
    );
`else
    modport master (
        output start, op, a, b,
        input  busy, done, f, cout, overflow
    );
    modport slave (
        input  start, op, a, b,
        output busy, done, f, cout, overflow
    );
`endif
endinterface

// File: rtl/sub_seq_ctl.sv
// Nibble-serial add/subtract sequencer; one 4-bit fulladder slice per clock, optional zero flag via SUB_SEQ_ZERO_FLAG_EN.
// Latency N+1 cycles (N=WIDTH/4) from accepted start to done; start is ignored, not queued, while busy.
// Operands are latched on accept, so input changes during RUN have no effect.

module fulladder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ cin;
    assign co = (x & y) | (cin & (x ^ y));
endmodule

module sub_seq_ctl #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    sub_seq_ctl_if.slave bus
);
    localparam int N  = WIDTH / 4;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] f_q;
    logic             carry;
    logic             busy_q;
    logic             done_q;
    logic             cout_q;
    logic             ovf_q;
    logic [3:0]       slice_sum;
    logic [4:0]       c;

    // Operand registers shift right one nibble per slice, so the adder always sees bits [3:0].
    assign c[0] = carry;
    for (genvar i = 0; i < 4; i++) begin : g_fa
        fulladder u_fa (
            .x   (a_q[i]),
            .y   (b_q[i]),
            .cin (c[i]),
            .s   (slice_sum[i]),
            .co  (c[i+1])
        );
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.f        = f_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;

`ifdef SUB_SEQ_ZERO_FLAG_EN
    logic zero_q;
    assign bus.zero = zero_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            f_q    <= '0;
            carry  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
`ifdef SUB_SEQ_ZERO_FLAG_EN
            zero_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        // Subtract is a + ~b + 1: invert b here and seed the carry with op.
                        a_q    <= bus.a;
                        b_q    <= bus.op ? ~bus.b : bus.b;
                        carry  <= bus.op;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end else begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    f_q[{cnt, 2'b00} +: 4] <= slice_sum;
                    carry <= c[4];
                    a_q   <= a_q >> 4;
                    b_q   <= b_q >> 4;
                    if (cnt == LAST) begin
                        cnt    <= '0;
                        cout_q <= c[4];
                        ovf_q  <= c[3] ^ c[4];
`ifdef SUB_SEQ_ZERO_FLAG_EN
                        // Lower nibbles already hold this operation's result by now.
                        zero_q <= ~|{slice_sum, f_q[WIDTH-5:0]};
`endif
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sub_seq_ctl.sv
// Directed, table-driven bench for sub_seq_ctl at WIDTH=32 and WIDTH=8.
module tb_sub_seq_ctl;
    logic clk = 1'b0;
    logic rst32;
    logic rst8;
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    sub_seq_ctl_if #(.WIDTH(32)) bus32 ();
    sub_seq_ctl_if #(.WIDTH(8))  bus8 ();

    sub_seq_ctl #(.WIDTH(32)) u_dut32 (.clk(clk), .reset(rst32), .bus(bus32));
    sub_seq_ctl #(.WIDTH(8))  u_dut8  (.clk(clk), .reset(rst8),  .bus(bus8));

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] f;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic launch32(input logic op, input logic [31:0] a, input logic [31:0] b);
        bus32.start = 1'b1;
        bus32.op    = op;
        bus32.a     = a;
        bus32.b     = b;
        @(posedge clk);
        @(negedge clk);
        bus32.start = 1'b0;
    endtask

    task automatic wait_done32(input int start_cyc, output int cyc);
        cyc = start_cyc;
        while (!bus32.done && cyc < 40) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic run8(input string name, input logic op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ef, input logic ec, input logic eo);
        int cyc;
        bus8.start = 1'b1;
        bus8.op    = op;
        bus8.a     = a;
        bus8.b     = b;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'b0;
        cyc = 1;
        while (!bus8.done && cyc < 20) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        check({name, "_lat"},  cyc, 3);
        check({name, "_f"},    bus8.f, ef);
        check({name, "_cout"}, bus8.cout, ec);
        check({name, "_ovf"},  bus8.overflow, eo);
        @(negedge clk);
    endtask

    initial begin
        int cyc;
        vecs[0] = '{1'b1, 32'h0000_0009, 32'h0000_0003, 32'h0000_0006, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 32'hACF1_3568, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
        vecs[8] = '{1'b1, 32'h0000_0003, 32'h0000_0009, 32'hFFFF_FFFA, 1'b0, 1'b0, 1'b0};

        bus32.start = 1'b0; bus32.op = 1'b0; bus32.a = '0; bus32.b = '0;
        bus8.start  = 1'b0; bus8.op  = 1'b0; bus8.a  = '0; bus8.b  = '0;
        rst32 = 1'b1;
        rst8  = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_busy", bus32.busy, 0);
        check("rst_done", bus32.done, 0);
        check("rst_f",    bus32.f, 0);
        check("rst_cout", bus32.cout, 0);
        check("rst_ovf",  bus32.overflow, 0);
        check("rst8_f",   bus8.f, 0);
        check("rst8_busy", bus8.busy, 0);
`ifdef SUB_SEQ_ZERO_FLAG_EN
        check("rst_zero", bus32.zero, 0);
`endif
        rst32 = 1'b0;
        rst8  = 1'b0;
        @(negedge clk);

        // Table: each op launched from IDLE, result checked at done and one cycle later.
        for (int i = 0; i < 9; i++) begin
            launch32(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("v%0d_busy", i), bus32.busy, 1);
            wait_done32(1, cyc);
            check($sformatf("v%0d_lat", i),   cyc, 9);
            check($sformatf("v%0d_nbusy", i), bus32.busy, 0);
            check($sformatf("v%0d_f", i),     bus32.f, vecs[i].f);
            check($sformatf("v%0d_cout", i),  bus32.cout, vecs[i].cout);
            check($sformatf("v%0d_ovf", i),   bus32.overflow, vecs[i].ovf);
`ifdef SUB_SEQ_ZERO_FLAG_EN
            check($sformatf("v%0d_zero", i),  bus32.zero, vecs[i].zero);
`endif
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", i), bus32.done, 0);
            check($sformatf("v%0d_hold", i),       bus32.f, vecs[i].f);
        end

        // Start during RUN is ignored; operand changes mid-run have no effect.
        launch32(1'b0, 32'h1111_1111, 32'h2222_2222);
        repeat (2) @(negedge clk);
        bus32.start = 1'b1; bus32.op = 1'b1; bus32.a = 32'hFFFF_FFFF; bus32.b = 32'h1;
        @(negedge clk);
        bus32.start = 1'b0; bus32.a = 32'hDEAD_BEEF; bus32.b = 32'h0BAD_F00D;
        wait_done32(4, cyc);
        check("hs_lat",  cyc, 9);
        check("hs_f",    bus32.f, 32'h3333_3333);
        check("hs_cout", bus32.cout, 0);
        @(negedge clk);
        check("hs_no_requeue", bus32.busy, 0);

        // Back-to-back: start asserted while done is high.
        launch32(1'b0, 32'h0000_0010, 32'h0000_0020);
        wait_done32(1, cyc);
        check("b2b_first_f", bus32.f, 32'h0000_0030);
        launch32(1'b1, 32'h8000_0000, 32'h0000_0001);
        check("b2b_busy", bus32.busy, 1);
        check("b2b_done", bus32.done, 0);
        check("b2b_f_stable", bus32.f, 32'h0000_0030);
        wait_done32(1, cyc);
        check("b2b_lat",  cyc, 9);
        check("b2b_f",    bus32.f, 32'h7FFF_FFFF);
        check("b2b_cout", bus32.cout, 1);
        check("b2b_ovf",  bus32.overflow, 1);

        // Reset in RUN cycle 4, with start also high: reset wins and the partial result is lost.
        launch32(1'b0, 32'h1234_5678, 32'h1111_1111);
        repeat (3) @(negedge clk);
        check("mid_busy", bus32.busy, 1);
        rst32 = 1'b1;
        bus32.start = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", bus32.busy, 0);
        check("mid_rst_done", bus32.done, 0);
        check("mid_rst_f",    bus32.f, 0);
        check("mid_rst_cout", bus32.cout, 0);
        check("mid_rst_ovf",  bus32.overflow, 0);
        rst32 = 1'b0;
        bus32.start = 1'b0;
        @(negedge clk);
        check("post_rst_idle", bus32.busy, 0);
        launch32(1'b0, 32'h0000_0100, 32'h0000_0200);
        wait_done32(1, cyc);
        check("post_rst_lat", cyc, 9);
        check("post_rst_f",   bus32.f, 32'h0000_0300);
        @(negedge clk);

        run8("w8_add",  1'b0, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0);
        run8("w8_ovf",  1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
        run8("w8_sub",  1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
